adc_block_framer: RTL and testbench

Packs paired ADC samples from the two LTC2315 channels into fixed 256-word blocks: one header, 127 interleaved A/B sample pairs, one trailer. It sits between the ADC capture logic (`adc_01_cs_st` strobe plus 12-bit data) and the `fifo_acp` write port that feeds `Ethernet_module_upper`. Every block that enters the FIFO is therefore complete and self-describing, so a full block is available whenever `rd_data_count[8]` is set.

---
 rtl/adc_block_framer_if.sv | 26 ++
 rtl/adc_block_framer.sv | 165 ++++++++++++++++
 tb/tb_adc_block_framer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_block_framer_if.sv
// Signal bundle between the ADC capture logic, adc_block_framer and the fifo_acp write port.
// The master drives the capture and FIFO-status inputs; the slave (the framer) drives the write side and status.
interface adc_block_framer_if;
  logic        en;
  logic        data_in_en;
  logic [15:0] DATA_IN_A;
  logic [15:0] DATA_IN_B;
  logic [8:0]  fifo_wr_count;
  logic        fifo_full;
  logic [15:0] fifo_din;
  logic        fifo_wr_en;
  logic [7:0]  seq_num;
  logic [15:0] drop_count;
  logic        busy;
  logic        err_full;

  modport master (
    output en, data_in_en, DATA_IN_A, DATA_IN_B, fifo_wr_count, fifo_full,
    input  fifo_din, fifo_wr_en, seq_num, drop_count, busy, err_full
  );

  modport slave (
    input  en, data_in_en, DATA_IN_A, DATA_IN_B, fifo_wr_count, fifo_full,
    output fifo_din, fifo_wr_en, seq_num, drop_count, busy, err_full
  );
endinterface

// File: rtl/adc_block_framer.sv
// Packs A/B sample pairs into fixed blocks (header, 2*PAIRS data words, trailer) for fifo_acp.
// ADC_FRAMER_CHECKSUM_EN: trailer is the 16-bit sum of all data words; otherwise 16'hFFFF.
// state | meaning
// IDLE  | wait for an admitted strobe   HDR  | write header      WR_A/WR_B | write captured pair
// WAIT  | wait for next strobe or en=0  PAD  | zero-fill rest    TRL       | write trailer, bump seq
module adc_block_framer #(
  parameter int         PAIRS      = 127,
  parameter int         FIFO_DEPTH = 511,
  parameter logic [3:0] HDR_TAG    = 4'hA
) (
  input logic            clk_12,
  input logic            rst,
  adc_block_framer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, WR_A, WR_B, WAIT, PAD, TRL} state_t;

  localparam int         BLK_WORDS = 2 * PAIRS + 2;
  localparam logic [8:0] LAST_DATA = 9'(2 * PAIRS - 1);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic [15:0] drop_q, drop_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic [7:0]  seq_q, seq_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic        room, strobe, drop;
  logic [15:0] trailer;

  assign strobe = bus.data_in_en;
  assign room   = (FIFO_DEPTH - int'(bus.fifo_wr_count)) >= BLK_WORDS;

`ifdef ADC_FRAMER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == TRL) begin
      sum_d = '0;
    end else if (state_q == WR_A || state_q == WR_B || state_q == PAD) begin
      sum_d = sum_q + din_d;
    end
  end

  always_ff @(posedge clk_12) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign trailer = sum_q;
`else
  assign trailer = 16'hFFFF;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    ovf_d   = ovf_q;
    seq_d   = seq_q;
    wcnt_d  = wcnt_q;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strobe && bus.en) begin
          if (room) begin
            a_d     = bus.DATA_IN_A;
            b_d     = bus.DATA_IN_B;
            state_d = HDR;
          end else begin
            drop = 1'b1;
          end
        end
      end
      HDR: begin
        din_d   = {HDR_TAG, ovf_q, 3'b000, seq_q};
        wr_d    = 1'b1;
        ovf_d   = 1'b0;
        drop    = strobe;
        state_d = WR_A;
      end
      WR_A: begin
        din_d   = a_q;
        wr_d    = 1'b1;
        wcnt_d  = wcnt_q + 9'd1;
        drop    = strobe;
        state_d = WR_B;
      end
      WR_B: begin
        din_d   = b_q;
        wr_d    = 1'b1;
        wcnt_d  = wcnt_q + 9'd1;
        drop    = strobe;
        state_d = (wcnt_q == LAST_DATA) ? TRL : WAIT;
      end
      WAIT: begin
        // a strobe coinciding with en falling still gets its pair written
        if (strobe) begin
          a_d     = bus.DATA_IN_A;
          b_d     = bus.DATA_IN_B;
          state_d = WR_A;
        end else if (!bus.en) begin
          state_d = PAD;
        end
      end
      PAD: begin
        din_d   = 16'h0000;
        wr_d    = 1'b1;
        wcnt_d  = wcnt_q + 9'd1;
        drop    = strobe;
        state_d = (wcnt_q == LAST_DATA) ? TRL : PAD;
      end
      TRL: begin
        din_d   = trailer;
        wr_d    = 1'b1;
        seq_d   = seq_q + 8'd1;
        wcnt_d  = '0;
        drop    = strobe;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a drop during HDR belongs to the next block, so setting wins over the header clear
    if (drop) ovf_d = 1'b1;
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    err_d  = err_q | (bus.fifo_full & wr_q);
  end

  always_ff @(posedge clk_12) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      seq_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      seq_q   <= seq_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.fifo_din   = din_q;
  assign bus.fifo_wr_en = wr_q;
  assign bus.seq_num    = seq_q;
  assign bus.drop_count = drop_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err_full   = err_q;
endmodule

// File: tb/tb_adc_block_framer.sv
// Directed bench for adc_block_framer: full-size instance plus a PAIRS=2 instance for sequence wrap.
module tb_adc_block_framer;
  logic clk_12 = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [15:0] wq[$];
  int   small_writes = 0;

  always #5 clk_12 = ~clk_12;

  adc_block_framer_if bus ();
  adc_block_framer_if sbus ();

  adc_block_framer u_dut (.clk_12(clk_12), .rst(rst), .bus(bus.slave));
  adc_block_framer #(.PAIRS(2)) u_small (.clk_12(clk_12), .rst(rst), .bus(sbus.slave));

  always @(negedge clk_12) begin
    if (bus.fifo_wr_en) wq.push_back(bus.fifo_din);
    if (sbus.fifo_wr_en) small_writes++;
  end

  // called at a negedge; strobe is seen by exactly one rising edge
  task automatic strobe(input logic [15:0] a, input logic [15:0] b);
    bus.data_in_en = 1'b1;
    bus.DATA_IN_A  = a;
    bus.DATA_IN_B  = b;
    @(negedge clk_12);
    bus.data_in_en = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    for (int i = 0; i < 400 && bus.busy; i++) @(negedge clk_12);
    timed_out = bus.busy;
    repeat (2) @(negedge clk_12);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_12);
    checks++; if (bus.fifo_wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b want 0", bus.fifo_wr_en); end
    checks++; if (bus.fifo_din !== 16'h0) begin fails++; $display("FAIL rst_din: got %h want 0000", bus.fifo_din); end
    checks++; if (bus.seq_num !== 8'd0) begin fails++; $display("FAIL rst_seq: got %0d want 0", bus.seq_num); end
    checks++; if (bus.drop_count !== 16'd0) begin fails++; $display("FAIL rst_drop: got %0d want 0", bus.drop_count); end
    checks++; if (bus.busy !== 1'b0 || bus.err_full !== 1'b0) begin fails++; $display("FAIL rst_busy_err: got %b%b want 00", bus.busy, bus.err_full); end
    rst = 1'b0;
    @(negedge clk_12);
  endtask

  task automatic test_nominal();
    logic [15:0] sum = 16'h0;
    logic [15:0] exp_trl;
    int bad = 0;
    bit to;
    wq.delete();
    bus.en = 1'b1;
    for (int n = 0; n < 127; n++) begin
      strobe(16'(n), 16'(16'h100 + n));
      sum = sum + 16'(n) + 16'(16'h100 + n);
      if (n == 0) begin
        checks++; if (bus.busy !== 1'b1 || bus.fifo_wr_en !== 1'b0) begin fails++; $display("FAIL lat_c0: got busy=%b wr=%b want busy=1 wr=0", bus.busy, bus.fifo_wr_en); end
        @(negedge clk_12);
        checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 16'hA000) begin fails++; $display("FAIL lat_hdr: got wr=%b din=%h want wr=1 din=a000", bus.fifo_wr_en, bus.fifo_din); end
        @(negedge clk_12);
        checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 16'h0000) begin fails++; $display("FAIL lat_a: got wr=%b din=%h want wr=1 din=0000", bus.fifo_wr_en, bus.fifo_din); end
        @(negedge clk_12);
        checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 16'h0100) begin fails++; $display("FAIL lat_b: got wr=%b din=%h want wr=1 din=0100", bus.fifo_wr_en, bus.fifo_din); end
        repeat (4) @(negedge clk_12);
      end else begin
        repeat (7) @(negedge clk_12);
      end
    end
    wait_idle(to);
`ifdef ADC_FRAMER_CHECKSUM_EN
    exp_trl = sum;
`else
    exp_trl = 16'hFFFF;
`endif
    checks++; if (to || wq.size() != 256) begin fails++; $display("FAIL nominal_len: got %0d words (timeout=%b) want 256", wq.size(), to); end
    for (int n = 0; n < 127 && 2 * n + 2 < wq.size(); n++)
      if (wq[2*n+1] !== 16'(n) || wq[2*n+2] !== 16'(16'h100 + n)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL nominal_pairs: got %0d bad pairs want 0", bad); end
    checks++; if (wq[255] !== exp_trl) begin fails++; $display("FAIL nominal_trl: got %h want %h", wq[255], exp_trl); end
    checks++; if (bus.seq_num !== 8'd1) begin fails++; $display("FAIL nominal_seq: got %0d want 1", bus.seq_num); end
  endtask

  task automatic test_admission();
    logic [15:0] exp_trl;
    bit to;
    wq.delete();
    bus.en = 1'b1;
    bus.fifo_wr_count = 9'd300;
    strobe(16'h0123, 16'h0456);
    repeat (4) @(negedge clk_12);
    checks++; if (wq.size() != 0 || bus.busy !== 1'b0) begin fails++; $display("FAIL adm_refused: got %0d words busy=%b want 0 words busy=0", wq.size(), bus.busy); end
    checks++; if (bus.drop_count !== 16'd1) begin fails++; $display("FAIL adm_drop: got %0d want 1", bus.drop_count); end
    bus.fifo_wr_count = 9'd0;
    strobe(16'h0AAA, 16'h0BBB);
    repeat (3) @(negedge clk_12);
    bus.en = 1'b0;
    wait_idle(to);
`ifdef ADC_FRAMER_CHECKSUM_EN
    exp_trl = 16'h0AAA + 16'h0BBB;
`else
    exp_trl = 16'hFFFF;
`endif
    checks++; if (wq[0] !== 16'hA801) begin fails++; $display("FAIL adm_hdr: got %h want a801", wq[0]); end
    checks++; if (to || wq.size() != 256) begin fails++; $display("FAIL adm_len: got %0d words (timeout=%b) want 256", wq.size(), to); end
    checks++; if (wq[1] !== 16'h0AAA || wq[2] !== 16'h0BBB) begin fails++; $display("FAIL adm_pair: got %h %h want 0aaa 0bbb", wq[1], wq[2]); end
    checks++; if (wq[255] !== exp_trl) begin fails++; $display("FAIL adm_trl: got %h want %h", wq[255], exp_trl); end
  endtask

  task automatic test_early_stop();
    logic [15:0] sum = 16'h0;
    logic [15:0] exp_trl;
    int bad = 0;
    int zbad = 0;
    bit to;
    wq.delete();
    bus.fifo_full = 1'b1;
    repeat (3) @(negedge clk_12);
    checks++; if (bus.err_full !== 1'b0) begin fails++; $display("FAIL err_idle: got %b want 0", bus.err_full); end
    bus.en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (n == 9) bus.en = 1'b0;
      strobe(16'(16'h200 + n), 16'(16'h300 + n));
      sum = sum + 16'(16'h200 + n) + 16'(16'h300 + n);
      repeat (5) @(negedge clk_12);
    end
    wait_idle(to);
    bus.fifo_full = 1'b0;
`ifdef ADC_FRAMER_CHECKSUM_EN
    exp_trl = sum;
`else
    exp_trl = 16'hFFFF;
`endif
    checks++; if (to || wq.size() != 256) begin fails++; $display("FAIL stop_len: got %0d words (timeout=%b) want 256", wq.size(), to); end
    checks++; if (wq[0] !== 16'hA002) begin fails++; $display("FAIL stop_hdr: got %h want a002", wq[0]); end
    for (int n = 0; n < 10; n++)
      if (wq[2*n+1] !== 16'(16'h200 + n) || wq[2*n+2] !== 16'(16'h300 + n)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL stop_pairs: got %0d bad pairs want 0", bad); end
    for (int i = 21; i < 255 && i < wq.size(); i++) if (wq[i] !== 16'h0000) zbad++;
    checks++; if (zbad != 0) begin fails++; $display("FAIL stop_pad: got %0d nonzero pad words want 0", zbad); end
    checks++; if (wq[255] !== exp_trl) begin fails++; $display("FAIL stop_trl: got %h want %h", wq[255], exp_trl); end
    checks++; if (bus.err_full !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", bus.err_full); end
    checks++; if (bus.seq_num !== 8'd3) begin fails++; $display("FAIL stop_seq: got %0d want 3", bus.seq_num); end
  endtask

  task automatic test_burst();
    int bad = 0;
    bit to;
    wq.delete();
    bus.en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      strobe(16'(16'h400 + k), 16'(16'h500 + k));
      if (k == 1) begin
        checks++; if (bus.drop_count !== 16'd2) begin fails++; $display("FAIL burst_drop1: got %0d want 2", bus.drop_count); end
      end
      @(negedge clk_12);
    end
    repeat (2) @(negedge clk_12);
    bus.en = 1'b0;
    wait_idle(to);
    checks++; if (bus.drop_count !== 16'd5) begin fails++; $display("FAIL burst_drops: got %0d want 5", bus.drop_count); end
    checks++; if (to || wq.size() != 256) begin fails++; $display("FAIL burst_len: got %0d words (timeout=%b) want 256", wq.size(), to); end
    checks++; if (wq[0] !== 16'hA003) begin fails++; $display("FAIL burst_hdr: got %h want a003", wq[0]); end
    for (int j = 0; j < 4; j++)
      if (wq[2*j+1] !== 16'(16'h400 + 2*j) || wq[2*j+2] !== 16'(16'h500 + 2*j)) bad++;
    checks++; if (bad != 0 || wq[9] !== 16'h0000) begin fails++; $display("FAIL burst_pairs: got %0d bad pairs, word9=%h want 0 bad, 0000", bad, wq[9]); end
    wq.delete();
    bus.en = 1'b1;
    strobe(16'h0001, 16'h0002);
    repeat (3) @(negedge clk_12);
    bus.en = 1'b0;
    wait_idle(to);
    checks++; if (to || wq[0] !== 16'hA804) begin fails++; $display("FAIL burst_ovf_hdr: got %h (timeout=%b) want a804", wq[0], to); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bus.en = 1'b1;
    for (int n = 0; n < 50; n++) begin
      strobe(16'(16'h600 + n), 16'(16'h700 + n));
      repeat (4) @(negedge clk_12);
    end
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk_12);
    checks++; if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== 16'h0) begin fails++; $display("FAIL mid_outputs: got busy=%b wr=%b din=%h want 0 0 0000", bus.busy, bus.fifo_wr_en, bus.fifo_din); end
    checks++; if (bus.seq_num !== 8'd0 || bus.drop_count !== 16'd0 || bus.err_full !== 1'b0) begin fails++; $display("FAIL mid_status: got seq=%0d drop=%0d err=%b want 0 0 0", bus.seq_num, bus.drop_count, bus.err_full); end
    rst = 1'b0;
    @(negedge clk_12);
    wq.delete();
    strobe(16'h0055, 16'h0066);
    repeat (3) @(negedge clk_12);
    bus.en = 1'b0;
    wait_idle(to);
    checks++; if (wq[0] !== 16'hA000) begin fails++; $display("FAIL mid_hdr: got %h want a000", wq[0]); end
    checks++; if (to || wq.size() != 256) begin fails++; $display("FAIL mid_len: got %0d words (timeout=%b) want 256", wq.size(), to); end
  endtask

  task automatic test_saturation();
    wq.delete();
    bus.en = 1'b1;
    bus.fifo_wr_count = 9'd511;
    bus.data_in_en = 1'b1;
    repeat (65534) @(negedge clk_12);
    checks++; if (bus.drop_count !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h want fffe", bus.drop_count); end
    repeat (70000 - 65534) @(negedge clk_12);
    bus.data_in_en = 1'b0;
    @(negedge clk_12);
    checks++; if (bus.drop_count !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h want ffff", bus.drop_count); end
    checks++; if (wq.size() != 0 || bus.busy !== 1'b0) begin fails++; $display("FAIL sat_nowrite: got %0d words busy=%b want 0 0", wq.size(), bus.busy); end
    bus.fifo_wr_count = 9'd0;
  endtask

  task automatic test_seq_wrap();
    small_writes = 0;
    for (int blk = 0; blk < 256; blk++) begin
      sbus.en = 1'b1;
      sbus.data_in_en = 1'b1;
      sbus.DATA_IN_A = 16'(blk);
      sbus.DATA_IN_B = 16'(blk + 1);
      @(negedge clk_12);
      sbus.data_in_en = 1'b0;
      repeat (3) @(negedge clk_12);
      sbus.en = 1'b0;
      for (int i = 0; i < 20 && sbus.busy; i++) @(negedge clk_12);
      if (blk == 254) begin
        checks++; if (sbus.seq_num !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", sbus.seq_num); end
      end
    end
    @(negedge clk_12);
    checks++; if (sbus.seq_num !== 8'd0) begin fails++; $display("FAIL wrap_0: got %0d want 0", sbus.seq_num); end
    checks++; if (small_writes != 256 * 6) begin fails++; $display("FAIL wrap_words: got %0d want %0d", small_writes, 256 * 6); end
  endtask

  initial begin
    bus.en = 1'b0; bus.data_in_en = 1'b0; bus.DATA_IN_A = '0; bus.DATA_IN_B = '0;
    bus.fifo_wr_count = '0; bus.fifo_full = 1'b0;
    sbus.en = 1'b0; sbus.data_in_en = 1'b0; sbus.DATA_IN_A = '0; sbus.DATA_IN_B = '0;
    sbus.fifo_wr_count = '0; sbus.fifo_full = 1'b0;
    @(negedge clk_12);
    test_reset();
    test_nominal();
    test_admission();
    test_early_stop();
    test_burst();
    test_reset_mid();
    test_saturation();
    test_seq_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
